// File: rtl/pulse_mon_pkg.sv
// Shared types for the pulse pair monitor.
//   chan_state_e : per-channel FSM states (ARM, LOW, HIGH)
//   pulse_rpt_t  : per-channel completion report {vld, width, ok, too_long}
//   width_w()    : width of a measured run counter that saturates at max_w+1
// The report width field is sized for the largest supported MAX_W; users
// slice it down to width_w(MAX_W) bits.
package pulse_mon_pkg;

    localparam int RPT_WW = 8;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } chan_state_e;

    typedef struct packed {
        logic              vld;
        logic [RPT_WW-1:0] width;
        logic              ok;
        logic              too_long;
    } pulse_rpt_t;

    function automatic int width_w(input int max_w);
        return $clog2(max_w + 2);
    endfunction

endpackage

// File: rtl/pulse_chan.sv
// One strobe channel: measures each low-high-low pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : serial strobe
//   nxt        : report to be registered at the coming edge (combinational)
//   rpt        : registered report; vld/too_long are single-cycle,
//                width/ok hold until the next completion
module pulse_chan
    import pulse_mon_pkg::*;
#(
    parameter int MIN_W = 1,
    parameter int MAX_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output pulse_rpt_t nxt,
    output pulse_rpt_t rpt
);

    localparam int WW = width_w(MAX_W);
    localparam logic [WW-1:0] SAT = WW'(MAX_W + 1);
    localparam logic [WW-1:0] LO  = WW'(MIN_W);
    localparam logic [WW-1:0] HI  = WW'(MAX_W);

    chan_state_e   state, state_d;
    logic [WW-1:0] cnt, cnt_d;

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        nxt           = '0;
        nxt.width     = rpt.width;
        nxt.ok        = rpt.ok;
        case (state)
            // A high seen before any low has no known start; wait it out.
            ARM:  if (!din) state_d = LOW;
            LOW:  if (din) begin
                      state_d = HIGH;
                      cnt_d   = WW'(1);
                  end
            HIGH: if (din) begin
                      // Once saturated the counter stops, so too_long fires once.
                      if (cnt != SAT) begin
                          cnt_d        = cnt + 1'b1;
                          nxt.too_long = (cnt + 1'b1 == SAT);
                      end
                  end else begin
                      // Falling sample is also the leading low of the next pulse.
                      state_d   = LOW;
                      nxt.vld   = 1'b1;
                      nxt.width = RPT_WW'(cnt);
                      nxt.ok    = (cnt >= LO) && (cnt <= HI);
                  end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARM;
            cnt   <= '0;
            rpt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rpt   <= nxt;
        end
    end

endmodule

// File: rtl/pulse_pair_monitor.sv
// Checks the m/n strobes: per-channel pulse width legality and whether the
// two pulses coincide (same end cycle and equal legal width).
//   clk, rst_n          : clock, synchronous active-low reset
//   m, n                : serial strobes
//   m_vld/m_width/m_ok  : M completion report (n_* likewise for N)
//   too_long[1:0]       : single-cycle, run reached MAX_W+1 ([0]=M, [1]=N)
//   pair_vld/pair_match : either channel completed / both coincide
// Optional macro PULSE_MON_STATS_EN adds saturating counters
//   m_good_cnt, n_good_cnt, match_cnt, err_cnt (CNT_W bits each).
module pulse_pair_monitor
    import pulse_mon_pkg::*;
#(
    parameter int MIN_W = 1,
    parameter int MAX_W = 3,
    parameter int CNT_W = 16,
    localparam int WW   = width_w(MAX_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m,
    input  logic          n,
    output logic          m_vld,
    output logic [WW-1:0] m_width,
    output logic          m_ok,
    output logic          n_vld,
    output logic [WW-1:0] n_width,
    output logic          n_ok,
    output logic [1:0]    too_long,
    output logic          pair_vld,
    output logic          pair_match
`ifdef PULSE_MON_STATS_EN
    ,
    output logic [CNT_W-1:0] m_good_cnt,
    output logic [CNT_W-1:0] n_good_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    pulse_rpt_t m_nxt, m_rpt, n_nxt, n_rpt;
    logic       pair_vld_d, pair_match_d;

    pulse_chan #(.MIN_W(MIN_W), .MAX_W(MAX_W)) u_chan_m (
        .clk(clk), .rst_n(rst_n), .din(m), .nxt(m_nxt), .rpt(m_rpt)
    );

    pulse_chan #(.MIN_W(MIN_W), .MAX_W(MAX_W)) u_chan_n (
        .clk(clk), .rst_n(rst_n), .din(n), .nxt(n_nxt), .rpt(n_rpt)
    );

    // Same end cycle plus same width means same start cycle too.
    assign pair_vld_d   = m_nxt.vld | n_nxt.vld;
    assign pair_match_d = m_nxt.vld & n_nxt.vld & m_nxt.ok & n_nxt.ok &
                          (m_nxt.width == n_nxt.width);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_vld   <= 1'b0;
            pair_match <= 1'b0;
        end else begin
            pair_vld   <= pair_vld_d;
            pair_match <= pair_match_d;
        end
    end

    assign m_vld    = m_rpt.vld;
    assign m_width  = m_rpt.width[WW-1:0];
    assign m_ok     = m_rpt.ok;
    assign n_vld    = n_rpt.vld;
    assign n_width  = n_rpt.width[WW-1:0];
    assign n_ok     = n_rpt.ok;
    assign too_long = {n_rpt.too_long, m_rpt.too_long};

    // Upper width bits are always zero; too_long is consumed from rpt only.
    logic unused_bits;
    assign unused_bits = ^{m_rpt.width, n_rpt.width, m_nxt.too_long, n_nxt.too_long};

`ifdef PULSE_MON_STATS_EN
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic [1:0] err_inc;
    assign err_inc = {1'b0, m_nxt.vld & ~m_nxt.ok} + {1'b0, n_nxt.vld & ~n_nxt.ok};

    // Counters track the reports being registered so they line up with x_vld.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_good_cnt <= '0;
            n_good_cnt <= '0;
            match_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            m_good_cnt <= sat_add(m_good_cnt, {1'b0, m_nxt.vld & m_nxt.ok});
            n_good_cnt <= sat_add(n_good_cnt, {1'b0, n_nxt.vld & n_nxt.ok});
            match_cnt  <= sat_add(match_cnt, {1'b0, pair_match_d});
            err_cnt    <= sat_add(err_cnt, err_inc);
        end
    end
`else
    // No statistics state in this build.
`endif

endmodule
